// File: rtl/frame_detector_pkg.sv
// Shared constants, state encodings, buffered-frame record and the word-wide
// CRC-16/XMODEM step used by the frame detector.
package frame_detector_pkg;

  localparam logic [15:0] HEADER_WORD  = 16'hE0E0;
  localparam logic [15:0] TRAILER_WORD = 16'h0E0E;
  localparam int          MAX_WORDS    = 8;
  localparam int          DATA_W       = MAX_WORDS * 16;
  // payload + CRC + first trailer word, the most BODY ever has to hold
  localparam int          BUF_WORDS    = MAX_WORDS + 2;

  typedef enum logic [2:0] {
    P_HUNT,
    P_HDR2,
    P_CHAN,
    P_BODY,
    P_CHECK
  } parse_state_t;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } ser_state_t;

  typedef struct packed {
    logic [7:0]        ch;
    logic [3:0]        nwords;
    logic [DATA_W-1:0] gray;
  } frame_t;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] word);
    logic [15:0] c;
    c = crc ^ word;
    for (int i = 0; i < 16; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_detector_fifo.sv
// Synchronous FIFO of complete checked frames; a push while full is dropped,
// a simultaneous push and pop leave the occupancy unchanged.
module frame_fifo
  import frame_detector_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk_in,
  input  logic   rst_n,
  input  logic   i_push,
  input  frame_t i_data,
  input  logic   i_pop,
  output frame_t o_data,
  output logic   o_empty,
  output logic   o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  frame_t         r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk_in) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/frame_detector.sv
// Parses a framed 16-bit stream, checks its CRC-16/XMODEM, queues good frames
// and shifts their Gray-coded payload out MSB first on the selected channel.
module frame_detector
  import frame_detector_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  output logic        data_out_ch1, data_out_ch2, data_out_ch3, data_out_ch4,
  output logic        data_out_ch5, data_out_ch6, data_out_ch7, data_out_ch8,
  output logic        data_vld_ch1, data_vld_ch2, data_vld_ch3, data_vld_ch4,
  output logic        data_vld_ch5, data_vld_ch6, data_vld_ch7, data_vld_ch8,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic        crc_valid_o,
  output logic        crc_err
);

  parse_state_t      r_pstate, w_pnext;
  ser_state_t        r_sstate, w_snext;
  logic [15:0]       r_buf [BUF_WORDS];
  logic [3:0]        r_cnt;
  logic              r_prev_trl;
  logic [7:0]        r_ch;
  logic              r_crc_err;
  logic              w_chan_ok, w_trailer, w_overflow, w_match, w_push, w_pop;
  logic [3:0]        w_nwords;
  logic [15:0]       w_crc;
  logic [DATA_W-1:0] w_payload;
  frame_t            w_wr_frame, w_rd_frame;
  logic [DATA_W-1:0] r_sh;
  logic [7:0]        r_bits_left, r_sch, w_shamt, w_vld, w_out;
  logic              r_first;

  assign w_chan_ok  = (data_in[15:8] == 8'h00) && $onehot(data_in[7:0]);
  assign w_trailer  = (data_in == TRAILER_WORD) && r_prev_trl;
  // a 10th stored word is only legal as the first half of the trailer
  assign w_overflow = (r_cnt == 4'(BUF_WORDS)) ||
                      ((r_cnt == 4'(BUF_WORDS - 1)) && (data_in != TRAILER_WORD));

  always_comb begin
    w_pnext = r_pstate;
    case (r_pstate)
      P_HUNT:  if (data_in == HEADER_WORD) w_pnext = P_HDR2;
      P_HDR2:  w_pnext = (data_in == HEADER_WORD) ? P_CHAN : P_HUNT;
      P_CHAN:  w_pnext = w_chan_ok ? P_BODY : P_HUNT;
      P_BODY: begin
        if (w_trailer)       w_pnext = (r_cnt >= 4'd3) ? P_CHECK : P_HUNT;
        else if (w_overflow) w_pnext = P_HUNT;
      end
      // CHECK also hunts so a header arriving right after the trailer is kept
      P_CHECK: w_pnext = (data_in == HEADER_WORD) ? P_HDR2 : P_HUNT;
      default: w_pnext = P_HUNT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_pstate   <= P_HUNT;
      r_cnt      <= '0;
      r_prev_trl <= 1'b0;
      r_ch       <= '0;
      r_crc_err  <= 1'b0;
    end else begin
      r_pstate  <= w_pnext;
      r_crc_err <= (r_pstate == P_CHECK) && !w_match;
      if (r_pstate == P_CHAN) begin
        r_ch       <= data_in[7:0];
        r_cnt      <= '0;
        r_prev_trl <= 1'b0;
      end else if (r_pstate == P_BODY && !w_trailer) begin
        r_cnt      <= r_cnt + 4'd1;
        r_prev_trl <= (data_in == TRAILER_WORD);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (r_pstate == P_BODY && !w_trailer && r_cnt < 4'(BUF_WORDS)) r_buf[r_cnt] <= data_in;
  end

  // r_cnt still counts the first trailer word, so payload = r_cnt - 2
  assign w_nwords = r_cnt - 4'd2;

  always_comb begin
    w_crc     = '0;
    w_payload = '0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      if (4'(i) < w_nwords) begin
        w_crc     = crc16_step(w_crc, r_buf[i]);
        w_payload = {w_payload[DATA_W-17:0], r_buf[i]};
      end
    end
  end

  assign w_match    = (w_crc == r_buf[w_nwords]);
  assign w_push     = (r_pstate == P_CHECK) && w_match;
  assign w_wr_frame = '{ch: r_ch, nwords: w_nwords, gray: w_payload ^ (w_payload >> 1)};

  frame_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_wr_frame),
    .i_pop   (w_pop),
    .o_data  (w_rd_frame),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  assign w_pop   = (r_sstate == S_IDLE) && !fifo_empty;
  assign w_shamt = 8'(DATA_W) - {w_rd_frame.nwords, 4'b0000};

  always_comb begin
    w_snext = r_sstate;
    case (r_sstate)
      S_IDLE:  if (!fifo_empty) w_snext = S_SHIFT;
      S_SHIFT: if (r_bits_left == 8'd1) w_snext = S_IDLE;
      default: w_snext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_sstate    <= S_IDLE;
      r_sh        <= '0;
      r_bits_left <= '0;
      r_sch       <= '0;
      r_first     <= 1'b0;
    end else begin
      r_sstate <= w_snext;
      if (w_pop) begin
        r_sh        <= w_rd_frame.gray << w_shamt;
        r_bits_left <= {w_rd_frame.nwords, 4'b0000};
        r_sch       <= w_rd_frame.ch;
        r_first     <= 1'b1;
      end else if (r_sstate == S_SHIFT) begin
        r_sh        <= {r_sh[DATA_W-2:0], 1'b0};
        r_bits_left <= r_bits_left - 8'd1;
        r_first     <= 1'b0;
      end
    end
  end

  always_comb begin
    w_vld       = (r_sstate == S_SHIFT) ? r_sch : 8'h00;
    w_out       = w_vld & {8{r_sh[DATA_W-1]}};
    crc_valid_o = (r_sstate == S_SHIFT) && r_first;
  end

  assign crc_err = r_crc_err;
  assign {data_vld_ch8, data_vld_ch7, data_vld_ch6, data_vld_ch5,
          data_vld_ch4, data_vld_ch3, data_vld_ch2, data_vld_ch1} = w_vld;
  assign {data_out_ch8, data_out_ch7, data_out_ch6, data_out_ch5,
          data_out_ch4, data_out_ch3, data_out_ch2, data_out_ch1} = w_out;

endmodule

// File: tb/tb_frame_detector.sv
// Directed bench for frame_detector: expected frames go into a scoreboard queue
// as they are sent and are checked bit by bit when the DUT serializes them.
module tb_frame_detector;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic        data_out_ch1, data_out_ch2, data_out_ch3, data_out_ch4;
  logic        data_out_ch5, data_out_ch6, data_out_ch7, data_out_ch8;
  logic        data_vld_ch1, data_vld_ch2, data_vld_ch3, data_vld_ch4;
  logic        data_vld_ch5, data_vld_ch6, data_vld_ch7, data_vld_ch8;
  logic        fifo_empty, fifo_full, crc_valid_o, crc_err;

  frame_detector #(.FIFO_DEPTH(2)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .data_in(data_in),
    .data_out_ch1(data_out_ch1), .data_out_ch2(data_out_ch2),
    .data_out_ch3(data_out_ch3), .data_out_ch4(data_out_ch4),
    .data_out_ch5(data_out_ch5), .data_out_ch6(data_out_ch6),
    .data_out_ch7(data_out_ch7), .data_out_ch8(data_out_ch8),
    .data_vld_ch1(data_vld_ch1), .data_vld_ch2(data_vld_ch2),
    .data_vld_ch3(data_vld_ch3), .data_vld_ch4(data_vld_ch4),
    .data_vld_ch5(data_vld_ch5), .data_vld_ch6(data_vld_ch6),
    .data_vld_ch7(data_vld_ch7), .data_vld_ch8(data_vld_ch8),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .crc_valid_o(crc_valid_o), .crc_err(crc_err)
  );

  always #5 clk_in = ~clk_in;

  wire [7:0] vld  = {data_vld_ch8, data_vld_ch7, data_vld_ch6, data_vld_ch5,
                     data_vld_ch4, data_vld_ch3, data_vld_ch2, data_vld_ch1};
  wire [7:0] outs = {data_out_ch8, data_out_ch7, data_out_ch6, data_out_ch5,
                     data_out_ch4, data_out_ch3, data_out_ch2, data_out_ch1};

  typedef struct {
    logic [7:0]   ch;
    int           nbits;
    logic [127:0] gray;
  } exp_t;

  exp_t         sb[$];
  int           starts[$];
  int           compared = 0;
  int           mismatched = 0;
  int           cyc = 0;
  int           last_cyc = 0;
  int           exp_err = 0;
  int           err_seen = 0;
  int           frames_seen = 0;
  int           first_bit_cyc = 0;
  int           bit_idx = 0;
  logic         active = 1'b0;
  exp_t         cur;
  logic [127:0] got;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [127:0] p, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int b = n * 16 - 1; b >= 0; b--) begin
      fb = c[15] ^ p[b];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic logic [127:0] gray_model(input logic [127:0] p, input int n);
    logic [127:0] g;
    g = '0;
    for (int b = 0; b < n * 16; b++) g[b] = p[b] ^ ((b + 1 < n * 16) ? p[b+1] : 1'b0);
    return g;
  endfunction

  // Monitor: pops the scoreboard on each frame start and checks every serial cycle.
  always @(negedge clk_in) begin
    if (rst_n === 1'b1) begin
      chk("out_gated", outs & ~vld, 0);
      if (crc_err) err_seen++;
      if (crc_valid_o) begin
        chk("start_while_busy", active, 0);
        chk("sb_has_frame", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          cur           = sb.pop_front();
          active        = 1'b1;
          bit_idx       = 0;
          got           = '0;
          first_bit_cyc = cyc;
          frames_seen++;
          starts.push_back(cyc);
        end
      end
      if (active) begin
        chk("vld_sel", vld, cur.ch);
        got = {got[126:0], |(outs & cur.ch)};
        bit_idx++;
        if (bit_idx == cur.nbits) begin
          chk("frame_data", got, cur.gray);
          active = 1'b0;
        end
      end else begin
        chk("vld_idle", vld, 0);
      end
    end
  end

  task automatic drive(input logic [15:0] w);
    @(posedge clk_in);
    #1 data_in = w;
  endtask

  task automatic send_frame(input logic [7:0] ch, input int n, input logic [127:0] p,
                            input logic use_crc, input logic [15:0] crc_in,
                            input logic expect_out, input logic [127:0] exp_gray);
    logic [15:0] c;
    exp_t        e;
    c = use_crc ? crc_in : crc_model(p, n);
    if (expect_out) begin
      e.ch    = ch;
      e.nbits = n * 16;
      e.gray  = (exp_gray != 0) ? exp_gray : gray_model(p, n);
      sb.push_back(e);
    end
    drive(16'hE0E0);
    drive(16'hE0E0);
    drive({8'h00, ch});
    for (int i = 0; i < n; i++) drive(p[(n-1-i)*16 +: 16]);
    drive(c);
    drive(16'h0E0E);
    drive(16'h0E0E);
    last_cyc = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((sb.size() != 0 || active) && k < 3000) begin
      @(posedge clk_in);
      k++;
    end
    chk(tag, (sb.size() == 0) && !active, 1);
    repeat (3) @(posedge clk_in);
    #1;
  endtask

  initial begin
    logic [127:0] p;
    rst_n   = 1'b0;
    data_in = 16'h0000;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_vld", vld, 0);
    chk("rst_out", outs, 0);
    chk("rst_crc_valid", crc_valid_o, 0);
    chk("rst_crc_err", crc_err, 0);
    chk("rst_fifo_empty", fifo_empty, 1);
    chk("rst_fifo_full", fifo_full, 0);
    rst_n = 1'b1;
    drive(16'h0000);

    // ch1, single word, known Gray result and first-bit latency
    send_frame(8'h01, 1, 128'hA55A, 1'b0, 16'h0, 1'b1, 128'hF7F7);
    begin
      int k;
      k = 0;
      while (frames_seen < 1 && k < 50) begin
        @(posedge clk_in);
        k++;
      end
      chk("first_frame_seen", frames_seen >= 1, 1);
    end
    chk("latency", first_bit_cyc - last_cyc, 3);
    wait_idle("drain_a55a");

    // ch2, full 128-bit payload
    send_frame(8'h02, 8, 128'h0123456789ABCDEFFEDCBA9876543210, 1'b0, 16'h0, 1'b1, 128'h0);
    wait_idle("drain_128b");

    // ch3 with wrong CRC: error pulse only
    send_frame(8'h04, 1, 128'h1234, 1'b1, 16'hFFFF, 1'b0, 128'h0);
    exp_err++;
    repeat (6) drive(16'h0000);
    chk("crc_err_count", err_seen, exp_err);
    chk("bad_crc_fifo_empty", fifo_empty, 1);

    // ch3 with correct CRC
    send_frame(8'h04, 1, 128'h1234, 1'b0, 16'h0, 1'b1, 128'h1B2E);
    wait_idle("drain_1234");

    // malformed: trailer after one stored word, bad channel, header not repeated, overflow
    drive(16'hE0E0); drive(16'hE0E0); drive(16'h0001); drive(16'h1234);
    drive(16'h0E0E); drive(16'h0E0E);
    send_frame(8'h03, 1, 128'h5555, 1'b0, 16'h0, 1'b0, 128'h0);
    drive(16'hE0E0); drive(16'h0001); drive(16'h5555); drive(16'h0E0E); drive(16'h0E0E);
    drive(16'hE0E0); drive(16'hE0E0); drive(16'h0001);
    for (int i = 0; i < 10; i++) drive(16'h1111);
    drive(16'h0E0E); drive(16'h0E0E);
    repeat (6) drive(16'h0000);
    chk("malformed_no_err", err_seen, exp_err);
    chk("malformed_no_frame", frames_seen, 3);

    // payload word equal to the trailer pattern is still payload
    send_frame(8'h20, 2, 128'h0E0E5555, 1'b0, 16'h0, 1'b1, 128'h0);
    wait_idle("drain_embedded_trl");

    // four back-to-back full frames into a 2-deep FIFO: the fourth arrives while full
    starts.delete();
    for (int f = 0; f < 3; f++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      send_frame(8'h10 << f, 8, p, 1'b0, 16'h0, 1'b1, 128'h0);
    end
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    chk("fifo_full_after_3", fifo_full, 1);
    p = {$urandom, $urandom, $urandom, $urandom};
    send_frame(8'h80, 8, p, 1'b0, 16'h0, 1'b0, 128'h0);
    wait_idle("drain_burst");
    chk("burst_frames", starts.size(), 3);
    if (starts.size() == 3) begin
      chk("burst_gap_1", starts[1] - starts[0], 129);
      chk("burst_gap_2", starts[2] - starts[1], 129);
    end
    chk("burst_fifo_empty", fifo_empty, 1);

    // reset in the middle of a body whose tail would otherwise complete it
    drive(16'hE0E0); drive(16'hE0E0); drive(16'h0001); drive(16'h1111); drive(16'h2222);
    @(posedge clk_in);
    #1;
    rst_n   = 1'b0;
    data_in = crc_model(128'h11112222, 2);
    @(posedge clk_in);
    #1 rst_n = 1'b1;
    drive(16'h0E0E); drive(16'h0E0E); drive(16'h0000);
    send_frame(8'h08, 1, 128'hBEEF, 1'b0, 16'h0, 1'b1, 128'h0);
    wait_idle("drain_post_reset");
    chk("post_reset_frames", frames_seen, 8);
    chk("final_crc_err_count", err_seen, exp_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
